// File: rtl/dm_bus_master_if.sv
// dm_bus_master_if: command, write-data, read-response and memory-bus signals of dm_bus_master.
// The master modport is the bus initiator's view; the slave modport is the command source and peripheral side.
interface dm_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        err;
    logic        busy;
    logic        dm_w;
    logic        dm_r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_op;
    logic [31:0] rdata;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_op, cmd_len, wd_valid, wd_data, rsp_ready, rdata,
        output cmd_ready, wd_ready, rsp_valid, rsp_data, rsp_last, err, busy, dm_w, dm_r, addr, wdata, dm_op
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_op, cmd_len, wd_valid, wd_data, rsp_ready, rdata,
        input  cmd_ready, wd_ready, rsp_valid, rsp_data, rsp_last, err, busy, dm_w, dm_r, addr, wdata, dm_op
    );
endinterface

// File: rtl/dm_bus_master.sv
// dm_bus_master: single/burst bus initiator issuing one dm_w/dm_r beat per transfer over valid/ready channels.
// Every beat takes at least two clocks so the peripheral's negedge write sample and combinational read settle.
module dm_bus_master #(
    parameter logic [11:0] FIX_HI    = 12'hbf8,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input logic clk,
    input logic rst,
    dm_bus_master_if.master bus
);
    localparam logic [2:0] DM_OP_WD = 3'd0;
    localparam logic [2:0] DM_OP_BS = 3'd1;
    localparam logic [2:0] DM_OP_BZ = 3'd2;
    localparam logic [2:0] DM_OP_HS = 3'd3;
    localparam logic [2:0] DM_OP_HZ = 3'd4;
    localparam logic [2:0] DM_OP_SB = 3'd5;
    localparam logic [2:0] DM_OP_SH = 3'd6;

    typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BEAT, RD_BEAT, RD_RSP} state_t;

    state_t      state, state_nx;
    logic [7:0]  count;
    logic        op_ok;
    logic        take;
    logic        rsp_hs;
    logic        advance;
    logic [31:0] addr_nx;

    assign op_ok   = bus.cmd_write ? (bus.cmd_op inside {DM_OP_WD, DM_OP_SB, DM_OP_SH})
                                   : (bus.cmd_op inside {DM_OP_BS, DM_OP_BZ, DM_OP_HS, DM_OP_HZ, DM_OP_WD});
    assign take    = state == IDLE && bus.cmd_valid;
    assign rsp_hs  = state == RD_RSP && bus.rsp_ready;
    // GPIO-region bursts keep hammering the same register instead of walking the address
    assign addr_nx = bus.addr[31:20] == FIX_HI ? bus.addr : bus.addr + ADDR_STEP;
    assign advance = (state == WR_BEAT && count != 8'd0) || (rsp_hs && !bus.rsp_last);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take && op_ok) state_nx = bus.cmd_write ? WR_WAIT : RD_BEAT;
            WR_WAIT: if (bus.wd_valid) state_nx = WR_BEAT;
            WR_BEAT: state_nx = count == 8'd0 ? IDLE : WR_WAIT;
            RD_BEAT: state_nx = RD_RSP;
            RD_RSP:  if (rsp_hs) state_nx = bus.rsp_last ? IDLE : RD_BEAT;
            default: state_nx = IDLE;
        endcase
    end

    // cmd_ready is gated by rst because the async reset parks the state in IDLE
    always_comb begin
        bus.cmd_ready = rst && state == IDLE;
        bus.wd_ready  = state == WR_WAIT;
        bus.dm_w      = state == WR_BEAT;
        bus.dm_r      = state == RD_BEAT;
        bus.rsp_valid = state == RD_RSP;
        bus.busy      = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bus.addr     <= '0;
            bus.wdata    <= '0;
            bus.dm_op    <= '0;
            bus.rsp_data <= '0;
            bus.rsp_last <= 1'b0;
            bus.err      <= 1'b0;
            count        <= '0;
        end else begin
            bus.err <= take && !op_ok;
            if (take && op_ok) begin
                bus.addr  <= bus.cmd_addr;
                bus.dm_op <= bus.cmd_op;
                count     <= bus.cmd_len;
            end
            if (state == WR_WAIT && bus.wd_valid) bus.wdata <= bus.wd_data;
            if (state == RD_BEAT) begin
                bus.rsp_data <= bus.rdata;
                bus.rsp_last <= count == 8'd0;
            end
            if (advance) begin
                bus.addr <= addr_nx;
                count    <= count - 8'd1;
            end
        end
endmodule

// File: tb/tb_dm_bus_master.sv
// tb_dm_bus_master: directed checks of dm_bus_master against a 16-word memory and a GPIO keypad model.
module tb_dm_bus_master;
    localparam logic [2:0] WD = 3'd0, BS = 3'd1, BZ = 3'd2, HS = 3'd3, HZ = 3'd4, SB = 3'd5, SH = 3'd6;
    localparam logic [31:0] KEYPAD = 32'h7;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  op;
        logic [31:0] d;
        logic        e;
    } vec_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  op;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        both_seen = 1'b0;
    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] mem [16];
    beat_t       beats [$];
    vec_t        vecs [10];

    dm_bus_master_if b ();
    dm_bus_master dut (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    assign b.rdata = b.addr[31:20] == 12'hbf8 ? KEYPAD : mem[b.addr[5:2]];

    // peripheral model: samples writes on the falling edge, logs every bus beat
    always @(negedge clk) begin
        if (b.dm_w && b.dm_r) both_seen <= 1'b1;
        if (b.dm_w || b.dm_r) beats.push_back('{b.dm_w, b.addr, b.wdata, b.dm_op});
        if (b.dm_w && b.addr[31:20] != 12'hbf8) mem[b.addr[5:2]] <= b.wdata;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [2:0] op, input logic [7:0] len);
        int n;
        n = 0;
        b.cmd_valid = 1'b1;
        b.cmd_write = w;
        b.cmd_addr  = a;
        b.cmd_op    = op;
        b.cmd_len   = len;
        while (!b.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("cmd_timeout", 32'd0, 32'd1);
        @(negedge clk);
        b.cmd_valid = 1'b0;
    endtask

    task automatic put_wd(input logic [31:0] d);
        int n;
        n = 0;
        b.wd_valid = 1'b1;
        b.wd_data  = d;
        while (!b.wd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("wd_timeout", 32'd0, 32'd1);
        @(negedge clk);
        b.wd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] d, output logic l);
        int n;
        n = 0;
        while (!b.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rsp_timeout", 32'd0, 32'd1);
        d = b.rsp_data;
        l = b.rsp_last;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_dm_r", 32'(b.dm_r), 32'd0);
            chk("hold_valid", 32'(b.rsp_valid), 32'd1);
            chk("hold_data", b.rsp_data, d);
        end
        b.rsp_ready = 1'b1;
        @(negedge clk);
        b.rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t        v;
        int          nb;
        logic [31:0] d;
        logic        l;
        vecs[0] = '{1'b1, 32'h0000_0010, WD, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, WD, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0020, SB, 32'h0000_00A5, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0020, BZ, 32'h0000_00A5, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0024, SH, 32'h0000_1234, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0024, HS, 32'h0000_1234, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0010, SB, 32'h0, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0010, BS, 32'h0, 1'b1};
        vecs[8] = '{1'b1, 32'h0000_0010, HZ, 32'h0, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0010, HZ, 32'hDEAD_BEEF, 1'b0};
        b.cmd_valid = 1'b0;
        b.cmd_write = 1'b0;
        b.cmd_addr  = '0;
        b.cmd_op    = '0;
        b.cmd_len   = '0;
        b.wd_valid  = 1'b0;
        b.wd_data   = '0;
        b.rsp_ready = 1'b0;
        #12;
        chk("rst_dm_w", 32'(b.dm_w), 32'd0);
        chk("rst_dm_r", 32'(b.dm_r), 32'd0);
        chk("rst_addr", b.addr, 32'd0);
        chk("rst_wdata", b.wdata, 32'd0);
        chk("rst_dm_op", 32'(b.dm_op), 32'd0);
        chk("rst_rsp_valid", 32'(b.rsp_valid), 32'd0);
        chk("rst_rsp_data", b.rsp_data, 32'd0);
        chk("rst_rsp_last", 32'(b.rsp_last), 32'd0);
        chk("rst_err", 32'(b.err), 32'd0);
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_wd_ready", 32'(b.wd_ready), 32'd0);
        chk("rst_cmd_ready", 32'(b.cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(b.cmd_ready), 32'd1);

        nb = beats.size();
        send_cmd(1'b1, 32'h0, WD, 8'd3);
        for (int k = 0; k < 4; k++) put_wd(32'(k + 1));
        @(negedge clk);
        chk("preload_beats", 32'(beats.size()), 32'(nb + 4));
        for (int k = 0; k < 4; k++) chk("preload_addr", beats[nb + k].a, 32'(4 * k));

        for (int i = 0; i < 10; i++) begin
            v  = vecs[i];
            nb = beats.size();
            send_cmd(v.w, v.a, v.op, 8'd0);
            if (v.e) begin
                chk("err_pulse", 32'(b.err), 32'd1);
                chk("err_busy", 32'(b.busy), 32'd0);
                @(negedge clk);
                chk("err_one_cycle", 32'(b.err), 32'd0);
            end else if (v.w) begin
                put_wd(v.d);
                @(negedge clk);
                chk("wr_strobe", 32'(beats[nb].w), 32'd1);
                chk("wr_addr", beats[nb].a, v.a);
                chk("wr_data", beats[nb].d, v.d);
                chk("wr_op", 32'(beats[nb].op), 32'(v.op));
            end else begin
                get_rsp(0, d, l);
                chk("rd_data", d, v.d);
                chk("rd_last", 32'(l), 32'd1);
                chk("rd_addr", beats[nb].a, v.a);
                chk("rd_op", 32'(beats[nb].op), 32'(v.op));
            end
            chk("vec_beats", 32'(beats.size()), 32'(nb + (v.e ? 0 : 1)));
        end

        nb = beats.size();
        send_cmd(1'b0, 32'h0, WD, 8'd3);
        for (int k = 0; k < 4; k++) begin
            get_rsp(k == 1 ? 5 : 0, d, l);
            chk("burst_data", d, 32'(k + 1));
            chk("burst_last", 32'(l), 32'(k == 3));
        end
        chk("burst_beats", 32'(beats.size()), 32'(nb + 4));
        for (int k = 0; k < 4; k++) begin
            chk("burst_addr", beats[nb + k].a, 32'(4 * k));
            chk("burst_is_read", 32'(beats[nb + k].w), 32'd0);
        end

        nb = beats.size();
        send_cmd(1'b0, 32'hBF80_0014, WD, 8'd2);
        for (int k = 0; k < 3; k++) begin
            get_rsp(0, d, l);
            chk("gpio_data", d, KEYPAD);
            chk("gpio_last", 32'(l), 32'(k == 2));
            chk("gpio_addr", beats[nb + k].a, 32'hBF80_0014);
        end

        nb = beats.size();
        send_cmd(1'b0, 32'hBF7F_FFFC, WD, 8'd2);
        for (int k = 0; k < 3; k++) get_rsp(0, d, l);
        chk("cross_addr0", beats[nb].a, 32'hBF7F_FFFC);
        chk("cross_addr1", beats[nb + 1].a, 32'hBF80_0000);
        chk("cross_addr2", beats[nb + 2].a, 32'hBF80_0000);

        nb = beats.size();
        send_cmd(1'b1, 32'hFFFF_FFFC, WD, 8'd1);
        put_wd(32'h11);
        put_wd(32'h22);
        @(negedge clk);
        chk("wrap_beats", 32'(beats.size()), 32'(nb + 2));
        chk("wrap_addr0", beats[nb].a, 32'hFFFF_FFFC);
        chk("wrap_data0", beats[nb].d, 32'h11);
        chk("wrap_addr1", beats[nb + 1].a, 32'h0);
        chk("wrap_data1", beats[nb + 1].d, 32'h22);

        nb = beats.size();
        send_cmd(1'b1, 32'h40, WD, 8'd3);
        put_wd(32'hA1);
        put_wd(32'hA2);
        #2;
        chk("abort_pre_dm_w", 32'(b.dm_w), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_dm_w", 32'(b.dm_w), 32'd0);
        chk("abort_busy", 32'(b.busy), 32'd0);
        chk("abort_cmd_ready", 32'(b.cmd_ready), 32'd0);
        chk("abort_addr", b.addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        b.wd_valid = 1'b1;
        b.wd_data  = 32'hA3;
        repeat (10) @(negedge clk);
        chk("abort_idle_ready", 32'(b.cmd_ready), 32'd1);
        chk("abort_idle_busy", 32'(b.busy), 32'd0);
        chk("abort_wd_ready", 32'(b.wd_ready), 32'd0);
        b.wd_valid = 1'b0;
        chk("abort_beats", 32'(beats.size()), 32'(nb + 2));

        chk("strobe_exclusive", 32'(both_seen), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/dm_bus_master.md
Name: dm_bus_master

Overview:
Bus initiator that drives the data-memory/peripheral bus (dm_w, dm_r, addr, wdata, dm_op, rdata) on behalf of a command source such as a debug loader or a future DMA client.
- Accepts single or burst read/write commands over a valid/ready interface.
- Streams write data in over one valid/ready channel and read data out over another.
- Sits beside the CPU memory stage, upstream of the peripheral block.
- Issues one bus beat per transfer, timed so the peripheral's negedge write sampling and combinational read path are honoured.

Parameters:
FIX_HI, 12'hbf8, addr[31:20] value marking the GPIO region; bursts inside it keep a fixed address (register polling).
ADDR_STEP, 4, byte increment between burst beats outside the GPIO region.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
cmd_valid  input  1  command offered.
cmd_ready  output  1  high only in IDLE.
cmd_write  input  1  1 = write burst, 0 = read burst.
cmd_addr  input  32  start byte address.
cmd_op  input  3  DM_OP_* encoding from common.v.
cmd_len  input  8  beats minus one (1..256 beats).
wd_valid  input  1  write data offered.
wd_ready  output  1  write data accepted.
wd_data  input  32  write data.
rsp_valid  output  1  read data valid.
rsp_ready  input  1  read data consumer ready.
rsp_data  output  32  captured read data.
rsp_last  output  1  final beat of a read burst.
err  output  1  one-cycle pulse when a command is rejected.
busy  output  1  high when the state is not IDLE.
dm_w  output  1  bus write strobe.
dm_r  output  1  bus read strobe.
addr  output  32  bus address.
wdata  output  32  bus write data.
dm_op  output  3  bus op.
rdata  input  32  bus read data (combinational from the peripheral).

Behaviour:
- Reset (async, rst=0): state IDLE. Outputs: dm_w=0, dm_r=0, addr=0, wdata=0, dm_op=0, rsp_valid=0, rsp_data=0, rsp_last=0, err=0, busy=0, wd_ready=0, cmd_ready=0 while reset is asserted. Assertion mid-burst aborts the burst at once; strobes fall without waiting for a clock edge, and the remaining beats are dropped.
- States: IDLE, WR_WAIT, WR_BEAT, RD_BEAT, RD_RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready the block latches addr, op and len; remaining count = cmd_len.
  - Write with op not in {WD, SB, SH}, or read with op not in {BS, BZ, HS, HZ, WD}: err=1 for one cycle, stay IDLE.
  - Otherwise go to WR_WAIT (write) or RD_BEAT (read).
- WR_WAIT: wd_ready=1. On wd_valid, latch wd_data into wdata and go to WR_BEAT.
- WR_BEAT: dm_w=1 for exactly one clock. addr, wdata and dm_op are stable across the whole cycle so the peripheral's negedge sample is clean.
  - Next state: IDLE if count==0; else WR_WAIT with count-1 and the address advanced.
- RD_BEAT: dm_r=1 for exactly one clock. rdata is captured into rsp_data at the closing posedge; rsp_valid=1 and rsp_last=(count==0) from the next cycle. Go to RD_RSP.
- RD_RSP: the bus is idle (dm_r=0). rsp_data and rsp_last are held until rsp_valid&rsp_ready.
  - Then: IDLE if last; else RD_BEAT with count-1 and the address advanced. rsp_valid drops the cycle after the handshake.
- Throughput: minimum 2 clocks per beat in either direction. dm_w and dm_r are never high together.
- Address advance:
  - If addr[31:20]==FIX_HI, the address is unchanged, so repeated reads poll the same GPIO register.
  - Otherwise addr += ADDR_STEP, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
  - The region check uses the current beat address, so a burst that crosses into the GPIO region switches to fixed addressing there.
- dm_op is driven from the latched cmd_op for every beat. Between bursts, addr, wdata and dm_op hold their last values.
- A cmd_valid arriving while busy is not accepted and must stay asserted until it is.

Test Plan:
- Single write: cmd write, addr=0x00000010, op=WD, len=0; wd_data=0xDEADBEEF → exactly one dm_w cycle with addr=0x10, wdata=0xDEADBEEF; the next word read at 0x10 returns 0xDEADBEEF.
- Read burst: len=3 from 0x00000000 after memory is preloaded with 1,2,3,4 → dm_r beats at 0x0, 0x4, 0x8, 0xC; rsp_data 1,2,3,4; rsp_last only on the 4th beat.
- Backpressure: hold rsp_ready=0 for 5 cycles on beat 2 → dm_r stays low, rsp_data stays stable, no beat is lost.
- GPIO poll: read at 0xBF800014, op=WD, len=2, keypad value 0x7 → three beats all at 0xBF800014, each returning 0x00000007.
- Wrap and illegal op: write burst at 0xFFFFFFFC with len=1 → beats at 0xFFFFFFFC then 0x00000000. Read with op=SB → err pulses one cycle, busy stays 0.
- Reset mid-burst: pull rst low during WR_BEAT of beat 2 of 4 → dm_w falls immediately; after release the block is in IDLE with cmd_ready=1 and no further bus beats.
